// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR family: maximal-length tap masks for widths 2..32
// (bit i set means state[i] feeds the XOR) and the reset state.
package lfsr_pkg;

    localparam logic [31:0] LFSR_RESET_VAL = 32'd1;

    localparam logic [1:0]  LFSR_TAPS_2  = 2'h3;
    localparam logic [2:0]  LFSR_TAPS_3  = 3'h6;
    localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;
    localparam logic [4:0]  LFSR_TAPS_5  = 5'h14;
    localparam logic [5:0]  LFSR_TAPS_6  = 6'h30;
    localparam logic [6:0]  LFSR_TAPS_7  = 7'h60;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [8:0]  LFSR_TAPS_9  = 9'h110;
    localparam logic [9:0]  LFSR_TAPS_10 = 10'h240;
    localparam logic [10:0] LFSR_TAPS_11 = 11'h500;
    localparam logic [11:0] LFSR_TAPS_12 = 12'h829;
    localparam logic [12:0] LFSR_TAPS_13 = 13'h100D;
    localparam logic [13:0] LFSR_TAPS_14 = 14'h2015;
    localparam logic [14:0] LFSR_TAPS_15 = 15'h6000;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
    localparam logic [16:0] LFSR_TAPS_17 = 17'h12000;
    localparam logic [17:0] LFSR_TAPS_18 = 18'h20400;
    localparam logic [18:0] LFSR_TAPS_19 = 19'h40023;
    localparam logic [19:0] LFSR_TAPS_20 = 20'h90000;
    localparam logic [20:0] LFSR_TAPS_21 = 21'h140000;
    localparam logic [21:0] LFSR_TAPS_22 = 22'h300000;
    localparam logic [22:0] LFSR_TAPS_23 = 23'h420000;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
    localparam logic [24:0] LFSR_TAPS_25 = 25'h1200000;
    localparam logic [25:0] LFSR_TAPS_26 = 26'h2000023;
    localparam logic [26:0] LFSR_TAPS_27 = 27'h4000013;
    localparam logic [27:0] LFSR_TAPS_28 = 28'h9000000;
    localparam logic [28:0] LFSR_TAPS_29 = 29'h14000000;
    localparam logic [29:0] LFSR_TAPS_30 = 30'h20000029;
    localparam logic [30:0] LFSR_TAPS_31 = 31'h48000000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    // Default tap mask for a given width, zero-extended to 32 bits.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        case (width)
            2:       return 32'(LFSR_TAPS_2);
            3:       return 32'(LFSR_TAPS_3);
            4:       return 32'(LFSR_TAPS_4);
            5:       return 32'(LFSR_TAPS_5);
            6:       return 32'(LFSR_TAPS_6);
            7:       return 32'(LFSR_TAPS_7);
            8:       return 32'(LFSR_TAPS_8);
            9:       return 32'(LFSR_TAPS_9);
            10:      return 32'(LFSR_TAPS_10);
            11:      return 32'(LFSR_TAPS_11);
            12:      return 32'(LFSR_TAPS_12);
            13:      return 32'(LFSR_TAPS_13);
            14:      return 32'(LFSR_TAPS_14);
            15:      return 32'(LFSR_TAPS_15);
            16:      return 32'(LFSR_TAPS_16);
            17:      return 32'(LFSR_TAPS_17);
            18:      return 32'(LFSR_TAPS_18);
            19:      return 32'(LFSR_TAPS_19);
            20:      return 32'(LFSR_TAPS_20);
            21:      return 32'(LFSR_TAPS_21);
            22:      return 32'(LFSR_TAPS_22);
            23:      return 32'(LFSR_TAPS_23);
            24:      return 32'(LFSR_TAPS_24);
            25:      return 32'(LFSR_TAPS_25);
            26:      return 32'(LFSR_TAPS_26);
            27:      return 32'(LFSR_TAPS_27);
            28:      return 32'(LFSR_TAPS_28);
            29:      return 32'(LFSR_TAPS_29);
            30:      return 32'(LFSR_TAPS_30);
            31:      return 32'(LFSR_TAPS_31);
            32:      return LFSR_TAPS_32;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational Fibonacci feedback: XOR of the state bits selected by TAPS.
module lfsr_feedback #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = '0
) (
    input  logic [WIDTH-1:0] i_state,
    output logic             o_fb
);

    assign o_fb = ^(i_state & TAPS);

endmodule

// File: rtl/lfsr4.sv
// Fibonacci LFSR with synchronous seed load and serial output q = state[WIDTH-1].
// Optional macro LFSR_LOCKUP_GUARD_EN keeps the register out of the all-zero state.
module lfsr4
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
) (
    output logic             q,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load
);

    localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(LFSR_RESET_VAL);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_shift_val;

    lfsr_feedback #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_feedback (
        .i_state (r_state),
        .o_fb    (w_fb)
    );

`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is the lock-up state; substitute the reset value on both entry paths.
    assign w_load_val  = (seed == '0) ? RESET_STATE : seed;
    assign w_shift_val = (r_state == '0) ? RESET_STATE : {r_state[WIDTH-2:0], w_fb};
`else
    assign w_load_val  = seed;
    assign w_shift_val = {r_state[WIDTH-2:0], w_fb};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else if (load) begin
            r_state <= w_load_val;
        end else begin
            r_state <= w_shift_val;
        end
    end

    assign q = r_state[WIDTH-1];

endmodule

// File: tb/tb_lfsr4.sv
// Self-checking bench for lfsr4: a reference model pushes expected states into a
// queue as each cycle is driven; they are popped and compared at the next falling edge.
module tb_lfsr4;

    logic       clk;
    logic       rst;
    logic [3:0] seed;
    logic       load;
    logic       q;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [3:0] exp_q[$];
    logic [3:0] m_state;

    // Reference q stream starting from state 0001.
    logic q_stream [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    lfsr4 dut (
        .q    (q),
        .clk  (clk),
        .rst  (rst),
        .seed (seed),
        .load (load)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic r,
                                              input logic l, input logic [3:0] sd);
        logic [3:0] n;
        if (r) begin
            n = 4'b0001;
        end else if (l) begin
            n = sd;
`ifdef LFSR_LOCKUP_GUARD_EN
            if (n == 4'b0000) n = 4'b0001;
`endif
        end else begin
            n = {s[2:0], s[3] ^ s[2]};
`ifdef LFSR_LOCKUP_GUARD_EN
            if (s == 4'b0000) n = 4'b0001;
`endif
        end
        return n;
    endfunction

    // Driver: called at a falling edge; drives one cycle, then compares at the next falling edge.
    task automatic drive_cycle(input string tag, input logic r, input logic l, input logic [3:0] sd);
        logic [3:0] e;
        rst  = r;
        load = l;
        seed = sd;
        m_state = model_next(m_state, r, l, sd);
        exp_q.push_back(m_state);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_state"}, 32'(dut.r_state), 32'(e));
            check({tag, "_q"}, 32'(q), 32'(e[3]));
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        seed = 4'b0000;
        m_state = 4'b0001;
        @(negedge clk);
        check("reset_q", 32'(q), 32'd0);
        check("reset_state", 32'(dut.r_state), 32'd1);
        drive_cycle("reset_hold", 1'b1, 1'b0, 4'b0000);
        drive_cycle("reset_hold", 1'b1, 1'b1, 4'b1111);

        // Load 0001 and free-run a full period against the reference stream.
        drive_cycle("load1", 1'b0, 1'b1, 4'b0001);
        check("stream_0", 32'(q), 32'(q_stream[0]));
        for (int k = 1; k <= 15; k++) begin
            drive_cycle("run", 1'b0, 1'b0, 4'b0000);
            check($sformatf("stream_%0d", k), 32'(q), 32'(q_stream[k % 15]));
        end
        check("period_state", 32'(dut.r_state), 32'd1);

        // Load held for three edges, then release.
        for (int k = 0; k < 3; k++) drive_cycle("load_held", 1'b0, 1'b1, 4'b1010);
        drive_cycle("after_hold1", 1'b0, 1'b0, 4'b1010);
        check("after_hold1_c", 32'(dut.r_state), 32'b0101);
        drive_cycle("after_hold2", 1'b0, 1'b0, 4'b1010);
        check("after_hold2_c", 32'(dut.r_state), 32'b1011);

        // Reset beats load.
        drive_cycle("rst_load", 1'b1, 1'b1, 4'b1111);
        check("rst_load_c", 32'(dut.r_state), 32'd1);
        drive_cycle("run", 1'b0, 1'b0, 4'b0000);
        drive_cycle("run", 1'b0, 1'b0, 4'b0000);

        // Mid-sequence load of 1000.
        drive_cycle("mid_load", 1'b0, 1'b1, 4'b1000);
        check("mid_load_c", 32'(dut.r_state), 32'b1000);
        drive_cycle("mid_next", 1'b0, 1'b0, 4'b0000);
        check("mid_next_c", 32'(dut.r_state), 32'b0001);

        // Asynchronous reset between edges.
        drive_cycle("pre_async", 1'b0, 1'b1, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        check("async_q", 32'(q), 32'd0);
        check("async_state", 32'(dut.r_state), 32'd1);
        m_state = 4'b0001;
        @(negedge clk);
        drive_cycle("async_hold", 1'b1, 1'b0, 4'b0000);
        drive_cycle("post_async", 1'b0, 1'b0, 4'b0000);
        check("post_async_c", 32'(dut.r_state), 32'b0010);

        // Zero seed.
        drive_cycle("zero_load", 1'b0, 1'b1, 4'b0000);
`ifdef LFSR_LOCKUP_GUARD_EN
        check("zero_guard_load", 32'(dut.r_state), 32'b0001);
        drive_cycle("zero_guard_run", 1'b0, 1'b0, 4'b0000);
        check("zero_guard_next", 32'(dut.r_state), 32'b0010);
`else
        for (int k = 0; k < 10; k++) begin
            drive_cycle("zero_run", 1'b0, 1'b0, 4'b0000);
            check("zero_lock", 32'(dut.r_state), 32'd0);
        end
`endif

        // Randomised mix of loads and shifts.
        drive_cycle("rand_start", 1'b0, 1'b1, 4'b0110);
        for (int k = 0; k < 40; k++) begin
            drive_cycle("rand", 1'b0, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr4.md
# lfsr4

Parameterised Fibonacci linear-feedback shift register with a serial output bit. It can be loaded synchronously with a seed. It sits in the pseudo-random/test-pattern path, where it supplies one pseudo-random bit per clock to downstream logic. The default configuration is a 4-bit maximal-length register with period 15.

## Interface
- `WIDTH`, default 4: state register width; legal range 2..32.
- `TAPS`, default 4'b1100 (polynomial x^4+x^3+1): a 1 in bit i includes `state[i]` in the feedback XOR.
- `clk`  input  1: single clock; all state updates occur on its rising edge.
- `rst`  input  1: reset; asynchronous and active-high.
- `q`  output  WIDTH-independent 1 bit: serial output, equal to `state[WIDTH-1]`.
- `seed`  input  WIDTH: value loaded into the state when `load` is high.
- `load`  input  1: synchronous seed-load strobe.
- Positional port order is fixed as `q, clk, rst, seed, load`.

## Operation
- Internal register `state[WIDTH-1:0]`.
- Reset: `state` = 1 (LSB set, all other bits 0), so `q` = 0.
- Feedback: `fb = ^(state & TAPS)`.
- Per rising edge, in priority order:
  - `rst` high: hold the reset value.
  - `load` high: `state <= seed`.
  - Otherwise shift left: `state <= {state[WIDTH-2:0], fb}`.
- `q` is purely a register bit. There is no combinational path from any input to `q`.
- Default sequence from 0001: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then back to 0001.
- Resulting `q` stream from 0001: 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1, repeating.
- An all-zero state is a lock-up state. It can only be entered by loading `seed` = 0 (see Configuration).

## Timing
- Load latency: 1 cycle. After the edge where `load` is sampled high, `state` = `seed` and `q` = `seed[WIDTH-1]`.
- Holding `load` high for N edges reloads `seed` on every one of those edges, so no shifting occurs while `load` is high.
- Shifting resumes on the first edge where `load` is low.
- Reset assertion clears the register immediately, independent of `clk`. `rst` and `load` asserted together: reset wins.
- Reset deasserted mid-sequence: the state restarts from 1.

## Configuration
- `LFSR_LOCKUP_GUARD_EN`:
  - Defined: the state can never be all zeros. A load of `seed` = 0 stores 1 instead, and a zero state is replaced by 1 on the next shift edge.
  - Undefined: `seed` = 0 is stored as-is, and the register stays at 0 (`q` = 0) until the next reset or a non-zero load.

## Structure
- Shared package `lfsr_pkg` holds:
  - maximal-length default tap constants for widths 2..32 (`LFSR_TAPS_4` = 4'b1100 and so on);
  - the reset-value constant.
- One natural sub-module, `lfsr_feedback`: combinational `fb` computation from `state` and `TAPS`.
- The top level holds the register, the priority mux and the guard logic.

## Test plan
- Reset: pulse `rst` asynchronously between edges -> `q` = 0 and `state` = 0001 immediately; stays 0001 while `rst` is high across clock edges.
- Load and run: `seed` = 0001 with `load` for one edge, then free-run 15 edges -> `q` = 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 and `state` returns to 0001.
- Load held: `load` high for 3 edges with `seed` = 1010 -> `state` stays 1010; after release, next states are 0101, then 1011.
- Priority: `rst` and `load` high with `seed` = 1111 -> `state` = 0001. Separately, `load` mid-sequence with `seed` = 1000 -> next state 1000, then 0001.
- Zero seed, macro undefined: load 0000 -> `state` stays 0000 for 10 edges.
- Zero seed, `LFSR_LOCKUP_GUARD_EN` defined: load 0000 -> `state` = 0001, then 0010.
